// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the fetch unit: PC controls, instruction-memory read port,
// decoder handshake, branch redirect and the delivered-instruction counter.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] pc_addr;
  logic                  pc_inc;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_load_data;

  logic                  mem_rd_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_valid;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic                  instr_ready;

  logic                  branch_req;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [15:0]           fetch_count;

  modport master (
    input  pc_addr, mem_rd_valid, mem_rd_data, instr_ready, branch_req, branch_target,
    output pc_inc, pc_load, pc_load_data, mem_rd_req, mem_addr,
           instr_valid, instr_data, instr_addr, fetch_count
  );

  modport slave (
    output pc_addr, mem_rd_valid, mem_rd_data, instr_ready, branch_req, branch_target,
    input  pc_inc, pc_load, pc_load_data, mem_rd_req, mem_addr,
           instr_valid, instr_data, instr_addr, fetch_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: reads memory at the PC, hands words to decode over valid/ready,
// and redirects on branch, draining a read that was already in flight.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input logic                clk,
  input logic                reset_n,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d;
  logic [ADDR_WIDTH-1:0] instr_addr_q, instr_addr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [15:0]           fetch_count_q, fetch_count_d;
  logic                  take_w;

  // A word is kept only when memory answers in REQ and no redirect collides with it.
  assign take_w = (state_q == S_REQ) && bus.mem_rd_valid && !bus.branch_req;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_REQ;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
      instr_addr_q  <= '0;
      last_addr_q   <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      instr_data_q  <= instr_data_d;
      instr_addr_q  <= instr_addr_d;
      last_addr_q   <= last_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_valid_d = instr_valid_q;
    instr_data_d  = instr_data_q;
    instr_addr_d  = instr_addr_q;
    last_addr_d   = last_addr_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      S_REQ: begin
        last_addr_d = bus.pc_addr;
        if (take_w) begin
          state_d       = S_HOLD;
          instr_valid_d = 1'b1;
          instr_data_d  = bus.mem_rd_data;
          instr_addr_d  = bus.pc_addr;
        end else if (!bus.mem_rd_valid && bus.branch_req) begin
          state_d = S_DRAIN;
        end
      end
      // The stale read must still complete before a new address may be issued.
      S_DRAIN: begin
        if (bus.mem_rd_valid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (bus.branch_req) begin
          state_d       = S_REQ;
          instr_valid_d = 1'b0;
        end else if (bus.instr_ready) begin
          state_d       = S_REQ;
          instr_valid_d = 1'b0;
          fetch_count_d = fetch_count_q + 16'd1;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    bus.mem_rd_req   = 1'b0;
    bus.mem_addr     = bus.pc_addr;
    bus.pc_inc       = 1'b0;
    bus.pc_load      = 1'b0;
    bus.pc_load_data = bus.branch_target;
    if (reset_n) begin
      bus.mem_rd_req = (state_q != S_HOLD);
      bus.pc_inc     = take_w;
      bus.pc_load    = bus.branch_req;
    end
    if (state_q == S_DRAIN) bus.mem_addr = last_addr_q;
  end

  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_data  = instr_data_q;
  assign bus.instr_addr  = instr_addr_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC and latency-programmable memory models, directed
// vectors, hand-written redirect/reset sequences, and a randomized stream checked by a scoreboard.
module tb_instr_fetch_unit;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_n;

  instr_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int deliveries = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Program counter neighbour: increment wins over load.
  logic [AW-1:0] pc_q;
  always_ff @(posedge clk) begin
    if (!reset_n)         pc_q <= '0;
    else if (bus.pc_inc)  pc_q <= pc_q + 16'd1;
    else if (bus.pc_load) pc_q <= bus.pc_load_data;
  end
  assign bus.pc_addr = pc_q;

  // Memory: answers after 'lat' wait cycles with addr ^ 0xA5A5; tolerates dropped requests.
  int lat  = 1;
  int mcnt = 0;
  initial begin
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n || !bus.mem_rd_req) begin
        bus.mem_rd_valid = 1'b0;
        mcnt = 0;
      end else begin
        if (bus.mem_rd_valid) mcnt = 0;
        if (mcnt >= lat) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = bus.mem_addr ^ 16'hA5A5;
        end else begin
          bus.mem_rd_valid = 1'b0;
          mcnt++;
        end
      end
    end
  end

  // Scoreboard: expected address stream follows the program order implied by branches.
  typedef struct {
    logic          rst_n, br, rdy, inc, ld, req, mv, iv;
    logic [AW-1:0] tgt, ld_data, maddr, iaddr;
    logic [DW-1:0] idata;
    logic [15:0]   cnt;
  } snap_t;

  function automatic snap_t take_snap();
    snap_t s;
    s.rst_n = reset_n;          s.br    = bus.branch_req;  s.rdy   = bus.instr_ready;
    s.inc   = bus.pc_inc;       s.ld    = bus.pc_load;     s.req   = bus.mem_rd_req;
    s.mv    = bus.mem_rd_valid; s.iv    = bus.instr_valid; s.tgt   = bus.branch_target;
    s.ld_data = bus.pc_load_data; s.maddr = bus.mem_addr;  s.iaddr = bus.instr_addr;
    s.idata = bus.instr_data;   s.cnt   = bus.fetch_count;
    return s;
  endfunction

  initial begin
    snap_t prev, cur;
    logic [AW-1:0] exp_next;
    logic [15:0]   exp_cnt;
    prev = '{default: '0};
    exp_next = '0;
    exp_cnt  = '0;
    forever begin
      @(negedge clk);
      #3;
      cur = take_snap();
      if (!prev.rst_n) begin
        exp_next = '0;
        exp_cnt  = '0;
        chk("rst_valid", cur.iv, 1'b0);
        chk("rst_iaddr", cur.iaddr, 16'h0);
        chk("rst_idata", cur.idata, 16'h0);
      end else begin
        if (prev.br) exp_next = prev.tgt;
        if (prev.iv && prev.rdy && !prev.br) exp_cnt = exp_cnt + 16'd1;
        if (cur.iv && !prev.iv) begin
          chk("sb_addr", cur.iaddr, exp_next);
          chk("sb_data", cur.idata, exp_next ^ 16'hA5A5);
          chk("sb_inc_per_word", prev.inc, 1'b1);
          exp_next = exp_next + 16'd1;
          deliveries++;
        end else begin
          chk("sb_inc_without_word", prev.inc, 1'b0);
        end
        if (cur.iv && prev.iv) begin
          chk("sb_hold_addr", cur.iaddr, prev.iaddr);
          chk("sb_hold_data", cur.idata, prev.idata);
        end
        if (prev.req && !prev.mv && cur.req && cur.rst_n)
          chk("sb_maddr_stable", cur.maddr, prev.maddr);
      end
      chk("sb_count", cur.cnt, exp_cnt);
      chk("sb_inc_and_load", cur.inc & cur.ld, 1'b0);
      chk("sb_load", cur.ld, cur.br & cur.rst_n);
      chk("sb_load_data", cur.ld_data, cur.tgt);
      chk("sb_req", cur.req, cur.rst_n & !cur.iv);
      prev = cur;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_word(input string name, input int max_cyc);
    bit ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      if (bus.instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1'b1);
  endtask

  typedef struct {
    int          lat;
    int          rdly;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit            found;
    logic [15:0]   c0;
    vecs[0] = '{lat: 1, rdly: 0, addr: 16'h0000, data: 16'hA5A5, cnt: 16'd1};
    vecs[1] = '{lat: 1, rdly: 0, addr: 16'h0001, data: 16'hA5A4, cnt: 16'd2};
    vecs[2] = '{lat: 0, rdly: 0, addr: 16'h0002, data: 16'hA5A7, cnt: 16'd3};
    vecs[3] = '{lat: 2, rdly: 5, addr: 16'h0003, data: 16'hA5A6, cnt: 16'd4};

    reset_n = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.branch_req    = 1'b0;
    bus.branch_target = '0;
    repeat (3) step();
    bus.branch_req    = 1'b1;
    bus.branch_target = 16'h1234;
    #1;
    chk("rst_pc_load", bus.pc_load, 1'b0);
    chk("rst_req", bus.mem_rd_req, 1'b0);
    chk("rst_count", bus.fetch_count, 16'h0);
    bus.branch_req = 1'b0;
    step();
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].lat;
      wait_word("vec_timeout", 20);
      chk("vec_addr", bus.instr_addr, vecs[i].addr);
      chk("vec_data", bus.instr_data, vecs[i].data);
      chk("vec_count_before", bus.fetch_count, vecs[i].cnt - 16'd1);
      for (int k = 0; k < vecs[i].rdly; k++) begin
        step();
        chk("stall_valid", bus.instr_valid, 1'b1);
        chk("stall_addr", bus.instr_addr, vecs[i].addr);
        chk("stall_data", bus.instr_data, vecs[i].data);
        chk("stall_req", bus.mem_rd_req, 1'b0);
        chk("stall_inc", bus.pc_inc, 1'b0);
      end
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;
      chk("vec_valid_after", bus.instr_valid, 1'b0);
      chk("vec_count_after", bus.fetch_count, vecs[i].cnt);
    end

    // Branch colliding with returning read data.
    lat = 1;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.mem_rd_valid && bus.mem_rd_req && !bus.instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("colide_find", found, 1'b1);
    bus.branch_req    = 1'b1;
    bus.branch_target = 16'h0100;
    #1;
    chk("colide_inc", bus.pc_inc, 1'b0);
    chk("colide_load", bus.pc_load, 1'b1);
    step();
    bus.branch_req = 1'b0;
    chk("colide_dropped", bus.instr_valid, 1'b0);
    chk("colide_next_addr", bus.mem_addr, 16'h0100);
    wait_word("colide_timeout", 20);
    chk("colide_word_addr", bus.instr_addr, 16'h0100);
    chk("colide_word_data", bus.instr_data, 16'hA4A5);

    // Branch in HOLD with ready high: not counted, redirect to 0x0005.
    lat = 4;
    bus.instr_ready   = 1'b1;
    bus.branch_req    = 1'b1;
    bus.branch_target = 16'h0005;
    step();
    bus.branch_req  = 1'b0;
    bus.instr_ready = 1'b0;
    chk("holdbr_valid", bus.instr_valid, 1'b0);
    chk("holdbr_count", bus.fetch_count, 16'd4);
    chk("holdbr_addr", bus.mem_addr, 16'h0005);

    // Redirect to 0x0200 while the slow read of 0x0005 is pending.
    step();
    step();
    bus.branch_req    = 1'b1;
    bus.branch_target = 16'h0200;
    #1;
    chk("drain_load", bus.pc_load, 1'b1);
    step();
    bus.branch_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("drain_addr", bus.mem_addr, 16'h0005);
      chk("drain_no_word", bus.instr_valid, 1'b0);
      if (bus.mem_rd_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("drain_valid_seen", found, 1'b1);
    step();
    chk("drain_next_addr", bus.mem_addr, 16'h0200);
    chk("drain_next_req", bus.mem_rd_req, 1'b1);
    wait_word("drain_timeout", 20);
    chk("drain_word_addr", bus.instr_addr, 16'h0200);
    chk("drain_word_data", bus.instr_data, 16'hA7A5);

    // Reset while a read is pending.
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    chk("prerst_count", bus.fetch_count, 16'd5);
    chk("prerst_req", bus.mem_rd_req, 1'b1);
    reset_n = 1'b0;
    bus.branch_req    = 1'b1;
    bus.branch_target = 16'h0777;
    #1;
    chk("midrst_req", bus.mem_rd_req, 1'b0);
    chk("midrst_inc", bus.pc_inc, 1'b0);
    chk("midrst_load", bus.pc_load, 1'b0);
    step();
    bus.branch_req = 1'b0;
    chk("midrst_valid", bus.instr_valid, 1'b0);
    chk("midrst_iaddr", bus.instr_addr, 16'h0);
    chk("midrst_idata", bus.instr_data, 16'h0);
    chk("midrst_count", bus.fetch_count, 16'h0);
    reset_n = 1'b1;
    lat = 1;
    wait_word("restart_timeout", 20);
    chk("restart_addr", bus.instr_addr, 16'h0000);
    chk("restart_data", bus.instr_data, 16'hA5A5);

    // PC wrap 0xFFFF -> 0x0000.
    bus.branch_req    = 1'b1;
    bus.branch_target = 16'hFFFF;
    step();
    bus.branch_req = 1'b0;
    wait_word("wrap_timeout0", 20);
    chk("wrap_addr_ffff", bus.instr_addr, 16'hFFFF);
    chk("wrap_data_ffff", bus.instr_data, 16'h5A5A);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    wait_word("wrap_timeout1", 20);
    chk("wrap_addr_0000", bus.instr_addr, 16'h0000);
    chk("wrap_data_0000", bus.instr_data, 16'hA5A5);

    // Zero-wait memory with ready held high: one word every two cycles.
    lat = 0;
    bus.instr_ready = 1'b1;
    repeat (4) step();
    c0 = bus.fetch_count;
    repeat (20) step();
    chk("throughput", bus.fetch_count - c0, 16'd10);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
      lat = $urandom_range(0, 3);
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if (bus.branch_req) begin
        bus.branch_req = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        bus.branch_req = 1'b1;
        if ($urandom_range(0, 7) == 0) bus.branch_target = 16'hFFFE + 16'($urandom_range(0, 1));
        else bus.branch_target = 16'($urandom);
      end
    end
    step();
    reset_n = 1'b1;
    bus.branch_req  = 1'b0;
    bus.instr_ready = 1'b0;
    repeat (3) step();
    chk("progress", deliveries > 200, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
